// File: rtl/hub_pkg.sv
// Shared constants and types for the hub memory arbiter.
// Optional build macro used by this slice: HUB_SKIP_IDLE_EN (see hub_slot_next).
package hub_pkg;
    localparam int NCOG_DEF = 8;
    localparam int HUB_AW   = 14;
    localparam int HUB_DW   = 32;
    localparam int HUB_WB   = 4;

    typedef logic [$clog2(NCOG_DEF)-1:0] slot_t;

    typedef struct packed {
        logic              w;
        logic [HUB_WB-1:0] wb;
        logic [HUB_AW-1:0] a;
        logic [HUB_DW-1:0] d;
    } hub_req_t;
endpackage

// File: rtl/hub_slot_next.sv
// Next hub slot owner.
// Default build: strict rotation (slot + 1 modulo NCOG), fixed cog timing.
// HUB_SKIP_IDLE_EN: work-conserving search for the next requesting cog at or
// after slot+1, skipping cogs that still have an access in flight.
module hub_slot_next
    import hub_pkg::*;
#(
    parameter  int NCOG = NCOG_DEF,
    localparam int SW   = $clog2(NCOG)
) (
    input  logic [SW-1:0]   i_slot,
    input  logic [NCOG-1:0] i_req,
    input  logic [NCOG-1:0] i_pend,
    output logic [SW-1:0]   o_slot_nxt
);

`ifdef HUB_SKIP_IDLE_EN
    logic          w_found;
    logic [SW-1:0] w_cand;

    // Cyclic priority search; the current owner itself is tried last.
    always_comb begin
        w_found    = 1'b0;
        w_cand     = '0;
        o_slot_nxt = i_slot + SW'(1);
        for (int i = 1; i <= NCOG; i++) begin
            w_cand = i_slot + SW'(i);
            if (!w_found && i_req[w_cand] && !i_pend[w_cand]) begin
                w_found    = 1'b1;
                o_slot_nxt = w_cand;
            end
        end
    end
`else
    logic w_unused;

    // Request and pending masks only matter to the skip-idle search.
    assign w_unused   = ^{i_req, i_pend};
    assign o_slot_nxt = i_slot + SW'(1);
`endif

endmodule

// File: rtl/hub_arbiter.sv
// Hub memory time-slot arbiter: one window per two clocks, one slot per
// window, registered memory-port drive and a one-cycle ack two cycles after
// the grant. Build macro HUB_SKIP_IDLE_EN selects work-conserving slot
// selection; without it the rotation is strict and cog timing deterministic.
module hub_arbiter
    import hub_pkg::*;
#(
    parameter  int NCOG = NCOG_DEF,
    parameter  int AW   = HUB_AW,
    localparam int SW   = $clog2(NCOG)
) (
    input  logic                 clk_cog,
    input  logic                 nres,
    input  logic [NCOG-1:0]      req,
    input  logic [NCOG-1:0]      req_w,
    input  logic [4*NCOG-1:0]    req_wb,
    input  logic [AW*NCOG-1:0]   req_a,
    input  logic [32*NCOG-1:0]   req_d,
    output logic                 ena_bus,
    output logic                 w,
    output logic [3:0]           wb,
    output logic [AW-1:0]        a,
    output logic [31:0]          d,
    input  logic [31:0]          mem_q,
    output logic [NCOG-1:0]      ack,
    output logic [31:0]          rdata,
    output logic [SW-1:0]        slot
);

    // r_phase high marks the setup cycle; the window (ena_bus) follows it.
    logic            r_phase;
    // r_v0/r_c0: access on the bus this cycle; r_v1/r_c1: memory data due now.
    logic            r_v0;
    logic            r_v1;
    logic [SW-1:0]   r_c0;
    logic [SW-1:0]   r_c1;
    logic [SW-1:0]   w_slot_nxt;
    logic [NCOG-1:0] w_pend;
    hub_req_t        w_sel;

    // Fields of the current slot owner.
    always_comb begin
        w_sel.w  = req_w[slot];
        w_sel.wb = req_wb[int'(slot)*HUB_WB +: HUB_WB];
        w_sel.a  = HUB_AW'(req_a[int'(slot)*AW +: AW]);
        w_sel.d  = req_d[int'(slot)*HUB_DW +: HUB_DW];
    end

    // Cogs with an access in flight or an ack showing must not be re-picked.
    always_comb begin
        w_pend = ack;
        if (r_v0) w_pend[r_c0] = 1'b1;
        if (r_v1) w_pend[r_c1] = 1'b1;
    end

    hub_slot_next #(.NCOG(NCOG)) u_slot_next (
        .i_slot     (slot),
        .i_req      (req),
        .i_pend     (w_pend),
        .o_slot_nxt (w_slot_nxt)
    );

    // Phase toggle and the bus-enable strobe one cycle behind it.
    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            r_phase <= 1'b0;
            ena_bus <= 1'b0;
        end else begin
            r_phase <= ~r_phase;
            ena_bus <= r_phase;
        end
    end

    // Grant at the end of the setup cycle; idle windows keep a and d so the
    // memory just performs a harmless read.
    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            w    <= 1'b0;
            wb   <= '0;
            a    <= '0;
            d    <= '0;
            r_v0 <= 1'b0;
            r_c0 <= '0;
        end else if (r_phase && req[slot]) begin
            w    <= w_sel.w;
            wb   <= w_sel.wb;
            a    <= AW'(w_sel.a);
            d    <= w_sel.d;
            r_v0 <= 1'b1;
            r_c0 <= slot;
        end else begin
            w    <= 1'b0;
            wb   <= '0;
            r_v0 <= 1'b0;
        end
    end

    // Slot ownership moves on at the end of every window, used or not.
    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            slot <= '0;
        end else if (ena_bus) begin
            slot <= w_slot_nxt;
        end
    end

    // Capture memory data one cycle after the window and pulse the ack.
    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            r_v1  <= 1'b0;
            r_c1  <= '0;
            ack   <= '0;
            rdata <= '0;
        end else begin
            r_v1 <= r_v0;
            r_c1 <= r_c0;
            if (r_v1) begin
                ack   <= NCOG'(1) << r_c1;
                rdata <= mem_q;
            end else begin
                ack <= '0;
            end
        end
    end

endmodule
